// File: rtl/audio_parallel_to_serial_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_parallel_to_serial_pkg: shared types for the I2S DAC path   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package audio_parallel_to_serial_pkg;

   localparam int AUD_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_SYNC    = 3'd0,
      ST_SHIFT_L = 3'd1,
      ST_PAD_L   = 3'd2,
      ST_SHIFT_R = 3'd3,
      ST_PAD_R   = 3'd4
   } state_t;

   localparam logic c_LRCK_LEFT  = 1'b0;
   localparam logic c_LRCK_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/audio_parallel_to_serial_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_parallel_to_serial_if: stereo pair valid/ready handshake    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface audio_parallel_to_serial_if
   import audio_parallel_to_serial_pkg::*;
#(
   parameter int DATA_WIDTH = AUD_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] AUD_inL;
   logic [DATA_WIDTH-1:0] AUD_inR;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output AUD_inL, output AUD_inR, output in_valid, input in_ready);
   modport slave  (input AUD_inL, input AUD_inR, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/audio_lrck_edge_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_lrck_edge_detect: LRCK fall (left start) / rise (right)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module audio_lrck_edge_detect
   import audio_parallel_to_serial_pkg::*;
(
   input  wire logic clk,
   input  wire logic i_lrck,
   output logic      o_fall,
   output logic      o_rise
);
   logic r_lr_prev;

   // Tracking LRCK unconditionally also covers reset: no false edge afterwards.
   always_ff @(posedge clk) begin
      r_lr_prev <= i_lrck;
   end

   assign o_fall = (r_lr_prev == c_LRCK_RIGHT) && (i_lrck == c_LRCK_LEFT);
   assign o_rise = (r_lr_prev == c_LRCK_LEFT)  && (i_lrck == c_LRCK_RIGHT);
endmodule
`default_nettype wire

// File: rtl/audio_parallel_to_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_parallel_to_serial: I2S slave transmitter for WM8731 DAC    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module audio_parallel_to_serial
   import audio_parallel_to_serial_pkg::*;
#(
   parameter int DATA_WIDTH         = AUD_DATA_WIDTH,
   parameter bit REPEAT_ON_UNDERRUN = 1'b1
)(
   input  wire logic                   AUD_BCK,
   input  wire logic                   reset,
   input  wire logic                   AUD_LRCK,
   audio_parallel_to_serial_if.slave   s_in,
   output logic                        AUD_DACDAT,
   output logic                        underrun
);
   localparam int c_CNT_W = $clog2(DATA_WIDTH);

   state_t                r_state, w_state_nxt;
   logic                  r_hold_full;
   logic [DATA_WIDTH-1:0] r_hold_L, r_hold_R;
   logic [DATA_WIDTH-1:0] r_last_L, r_last_R;
   logic [DATA_WIDTH-1:0] r_R_pend;
   logic [DATA_WIDTH-1:0] r_sh, w_sh_nxt;
   logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                  r_dac, w_dac_nxt;
   logic                  r_underrun;
   logic                  w_fall, w_rise, w_ready, w_accept;
   logic [DATA_WIDTH-1:0] w_frame_L, w_frame_R;

   audio_lrck_edge_detect u_edge (
      .clk    (AUD_BCK),
      .i_lrck (AUD_LRCK),
      .o_fall (w_fall),
      .o_rise (w_rise)
   );

   // A frame load frees the buffer in the same cycle, so it may refill at once.
   assign w_ready       = ~r_hold_full | w_fall;
   assign w_accept      = s_in.in_valid & w_ready;
   assign s_in.in_ready = w_ready;

   always_comb begin
      w_frame_L = '0;
      w_frame_R = '0;
      if (r_hold_full) begin
         w_frame_L = r_hold_L;
         w_frame_R = r_hold_R;
      end else if (REPEAT_ON_UNDERRUN) begin
         w_frame_L = r_last_L;
         w_frame_R = r_last_R;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dac_nxt   = 1'b0;
      w_sh_nxt    = r_sh << 1;
      w_cnt_nxt   = r_cnt;
      if (w_fall) begin
         w_state_nxt = ST_SHIFT_L;
         w_dac_nxt   = w_frame_L[DATA_WIDTH-1];
         w_sh_nxt    = w_frame_L << 1;
         w_cnt_nxt   = c_CNT_W'(DATA_WIDTH-1);
      end else if (w_rise && (r_state != ST_SYNC)) begin
         w_state_nxt = ST_SHIFT_R;
         w_dac_nxt   = r_R_pend[DATA_WIDTH-1];
         w_sh_nxt    = r_R_pend << 1;
         w_cnt_nxt   = c_CNT_W'(DATA_WIDTH-1);
      end else begin
         case (r_state)
            ST_SHIFT_L, ST_SHIFT_R: begin
               w_dac_nxt = r_sh[DATA_WIDTH-1];
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
               // r_cnt counts bits still to go; at 1 this cycle drives bit 0.
               if (r_cnt == c_CNT_W'(1)) begin
                  w_state_nxt = (r_state == ST_SHIFT_L) ? ST_PAD_L : ST_PAD_R;
               end
            end
            default: w_dac_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge AUD_BCK) begin
      if (reset) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge AUD_BCK) begin
      if (reset) begin
         r_dac       <= 1'b0;
         r_underrun  <= 1'b0;
         r_hold_full <= 1'b0;
         r_hold_L    <= '0;
         r_hold_R    <= '0;
         r_last_L    <= '0;
         r_last_R    <= '0;
         r_R_pend    <= '0;
         r_sh        <= '0;
         r_cnt       <= '0;
      end else begin
         r_dac      <= w_dac_nxt;
         r_sh       <= w_sh_nxt;
         r_cnt      <= w_cnt_nxt;
         r_underrun <= w_fall & ~r_hold_full;
         if (w_fall) begin
            r_R_pend <= w_frame_R;
            if (r_hold_full) begin
               r_last_L <= r_hold_L;
               r_last_R <= r_hold_R;
            end
         end
         if (w_accept) begin
            r_hold_L    <= s_in.AUD_inL;
            r_hold_R    <= s_in.AUD_inR;
            r_hold_full <= 1'b1;
         end else if (w_fall) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   assign AUD_DACDAT = r_dac;
   assign underrun   = r_underrun;
endmodule
`default_nettype wire

// File: doc/audio_parallel_to_serial.md
Name: audio_parallel_to_serial

Overview:
- I2S transmitter. Serializes 16-bit left/right sample pairs onto AUD_DACDAT for the WM8731 DAC.
- The codec is bus master and drives AUD_BCK and AUD_LRCK. This block is a slave and runs entirely on posedge AUD_BCK.
- The controller side supplies stereo pairs through a valid/ready handshake into a one-deep holding buffer.
- Mirrors the ADC receive path: MSB first, one-BCK I2S delay, LRCK=0 is the left channel, LRCK=1 is the right channel.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- REPEAT_ON_UNDERRUN, 1, when no new pair is available: 1 replays the last pair, 0 sends zeros.

Ports:
- AUD_BCK  in  1  audio bit clock; the only clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- AUD_LRCK  in  1  left-right clock from the codec.
- AUD_inL  in  DATA_WIDTH  left sample, two's complement.
- AUD_inR  in  DATA_WIDTH  right sample, two's complement.
- in_valid  in  1  AUD_inL/AUD_inR hold a valid pair.
- in_ready  out  1  holding buffer can accept a pair this cycle.
- AUD_DACDAT  out  1  serial DAC data, registered.
- underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset values:
  - AUD_DACDAT=0, underrun=0, in_ready=1.
  - holding buffer empty; shift/last-pair registers = 0; bit counter = 0; state = SYNC.
  - LRprev <= AUD_LRCK, so there is no false edge on the first cycle after reset.
- Edge detection, every cycle:
  - fallL = LRprev & ~AUD_LRCK; riseR = ~LRprev & AUD_LRCK; then LRprev <= AUD_LRCK.
- Handshake:
  - A pair is accepted on any cycle where in_valid & in_ready.
  - in_ready = ~hold_full | frame_load, where frame_load = fallL & state!=SYNC-exit-only.
  - Load and accept may occur in the same cycle: the old pair goes to the shifter and the new pair to the holding buffer, which stays full.
  - The holding buffer is never overwritten while full.
- Frame load, on fallL in any state:
  - If hold_full: L_sh <= hold_L, R_pend <= hold_R, last pair <= hold pair, hold_full <= 0 (unless refilled the same cycle).
  - If empty: load last pair (REPEAT_ON_UNDERRUN=1) or zeros (=0), and pulse underrun=1 for this cycle.
  - L and R of one pair always go out in the same frame; pairs are never split across frames.
- State machine:
  - SYNC: after reset, AUD_DACDAT=0. Ignore riseR. On the first fallL, do the frame load and go to SHIFT_L.
  - SHIFT_L / SHIFT_R: on the edge that enters the state, AUD_DACDAT <= bit DATA_WIDTH-1. On each following cycle, drive the next lower bit.
    - This cycle alignment gives the one-BCK I2S delay: the DAC samples the MSB on the second BCK rise after the LRCK edge.
  - After bit 0 has been driven, go to PAD_L / PAD_R.
  - PAD_L / PAD_R: AUD_DACDAT <= 0 until the next LRCK edge.
  - Any riseR (outside SYNC): AUD_DACDAT <= R_pend MSB, go to SHIFT_R.
  - Any fallL (outside SYNC): frame load, AUD_DACDAT <= new L MSB, go to SHIFT_L.
- Boundary conditions:
  - Slot shorter than DATA_WIDTH BCKs: the word is truncated. The new edge wins and restarts at the MSB of the other channel.
  - Slot longer: zero padding.
  - Edge of the same polarity twice, e.g. a glitch: each detected edge restarts its channel from the MSB.
  - Reset mid-word: everything returns to SYNC next cycle, the pending pair is discarded, and DACDAT=0.
  - underrun never fires in SYNC before the first fallL. It may fire on that first fallL.
- Latency: an accepted pair leaves at the next fallL. Its L MSB is on AUD_DACDAT in the same cycle as the fallL detection; its R MSB in the riseR cycle.

Decomposition:
- Shared package: AUD_DATA_WIDTH=16, the state encoding (SYNC, SHIFT_L, PAD_L, SHIFT_R, PAD_R), and the LRCK channel encoding constants (LEFT=0, RIGHT=1).
- One natural sub-module: audio_lrck_edge_detect (LRprev register, fallL/riseR outputs). The receiver may reuse it.
- Holding buffer and shifter stay inline.

Test Plan:
- Nominal, 32-BCK slots: push L=16'hA5C3, R=16'h0F0F before the first fallL. AUD_DACDAT shows 1010010111000011 starting the fallL cycle, 16 zeros of pad, then 0000111100001111 from the riseR cycle; no underrun.
- Loopback: feed AUD_DACDAT and LRCK into audio_serial_to_parallel with 8 random pairs. Each pair appears on AUD_outL/AUD_outR in order, bit-exact.
- Underrun: push one pair (16'h1234, 16'h8001) and nothing more. The second frame repeats 16'h1234/16'h8001 with an underrun pulse. With REPEAT_ON_UNDERRUN=0 it sends zeros.
- Backpressure:
  - Hold in_valid=1 with a new value each accepted cycle.
  - in_ready deasserts after the first accept.
  - The buffer stays full until the next fallL.
  - Load and accept happen in the same cycle; no pair is lost or duplicated.
- Short slot, 8 BCKs: L=16'hFFFF sends only 8 ones before riseR, and R starts at its MSB.
- Reset asserted mid-SHIFT_R: DACDAT=0 the next cycle, the state returns to SYNC, and the first riseR after release is ignored. Output resumes at the following fallL.
